// File: rtl/wb_arb_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the round-robin Wishbone B4 arbiter: cycle/burst types
// and the arbiter state machine.
package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC     = 3'b000;
  localparam logic [2:0] CTI_CONST_BURST = 3'b001;
  localparam logic [2:0] CTI_INC_BURST   = 3'b010;
  localparam logic [2:0] CTI_END         = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin picker: the search starts one past the previous
// owner and wraps, so the most recent owner has the lowest priority.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IW-1:0]          idx
);

  always_comb begin
    int          cand;
    logic [IW-1:0] c;
    logic        found;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    c     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      c = IW'(cand);
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
`timescale 1ns/1ps
// Round-robin Wishbone B4 arbiter: grants one master the slave port for its whole
// cyc envelope, with a per-access watchdog that errors out stalled slaves.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [dw-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int IW  = $clog2(NUM_MASTERS);
  localparam int SW  = dw / 8;
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [aw-1:0] adr_a [NUM_MASTERS];
  logic [dw-1:0] dat_a [NUM_MASTERS];
  logic [SW-1:0] sel_a [NUM_MASTERS];
  logic [2:0]    cti_a [NUM_MASTERS];
  logic [1:0]    bte_a [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_split
    assign adr_a[m] = wbm_adr_i[m*aw +: aw];
    assign dat_a[m] = wbm_dat_i[m*dw +: dw];
    assign sel_a[m] = wbm_sel_i[m*SW +: SW];
    assign cti_a[m] = wbm_cti_i[m*3 +: 3];
    assign bte_a[m] = wbm_bte_i[m*2 +: 2];
  end

  arb_state_t             state, state_nxt;
  logic [IW-1:0]          owner, last, pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt, grant_q;
  logic [WCW-1:0]         wcnt;
  logic                   owned, own_cyc, own_stb, term, expire, timeout_q;

  wb_rr_pick #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_pick (
    .req  (wbm_cyc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign owned   = (state == ST_OWNED);
  assign own_cyc = owned & wbm_cyc_i[owner];
  assign own_stb = owned & wbm_stb_i[owner];
  assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A slave termination in the expiry cycle beats the watchdog.
  assign expire  = (TIMEOUT != 0) && own_stb && !term && (wcnt == WCW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|wbm_cyc_i) state_nxt = ST_OWNED;
      ST_OWNED: if (!own_cyc)   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      owner     <= '0;
      grant_q   <= '0;
      last      <= IW'(NUM_MASTERS - 1);
      wcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= expire;
      if (!owned && |wbm_cyc_i) begin
        owner   <= pick_idx;
        grant_q <= pick_gnt;
      end
      if (owned && !own_cyc) begin
        last    <= owner;
        grant_q <= '0;
      end
      if (!own_stb || term || expire) wcnt <= '0;
      else                            wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (owned) begin
      wbs_adr_o        = adr_a[owner];
      wbs_dat_o        = dat_a[owner];
      wbs_sel_o        = sel_a[owner];
      wbs_we_o         = wbm_we_i[owner];
      wbs_cti_o        = cti_a[owner];
      wbs_bte_o        = bte_a[owner];
      wbs_cyc_o        = own_cyc;
      wbs_stb_o        = own_stb & ~expire;
      wbm_ack_o[owner] = wbs_ack_i;
      wbm_err_o[owner] = wbs_err_i | expire;
      wbm_rty_o[owner] = wbs_rty_i;
    end
  end

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
`timescale 1ns/1ps
// Scoreboard bench for wb_arbiter_rr: master tasks queue expected terminations and
// grants, a negedge monitor pops and compares whenever the arbiter answers.
module tb_wb_arbiter_rr;
  import wb_arb_pkg::*;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } exp_t;

  logic clk, rst_n;
  logic [31:0] m_adr [4];
  logic [31:0] m_dat [4];
  logic [3:0]  m_sel [4];
  logic [2:0]  m_cti [4];
  logic [1:0]  m_bte [4];
  logic [3:0]  m_we, m_cyc, m_stb;
  logic [127:0] adr_bus, dat_bus;
  logic [15:0]  sel_bus;
  logic [11:0]  cti_bus;
  logic [7:0]   bte_bus;

  logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_sel_o, grant_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic        s_ack, slave_en, force_ack;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q [4][$];
  logic [3:0] gnt_q [$];
  int   ack_cnt [4];
  logic [3:0] prev_g;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adr_bus[i*32 +: 32] = m_adr[i];
      dat_bus[i*32 +: 32] = m_dat[i];
      sel_bus[i*4 +: 4]   = m_sel[i];
      cti_bus[i*3 +: 3]   = m_cti[i];
      bte_bus[i*2 +: 2]   = m_bte[i];
    end
  end

  wb_arbiter_rr #(.NUM_MASTERS(4), .aw(32), .dw(32), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst_n),
    .wbm_adr_i(adr_bus),   .wbm_dat_i(dat_bus),   .wbm_sel_i(sel_bus),
    .wbm_we_i (m_we),      .wbm_cyc_i(m_cyc),     .wbm_stb_i(m_stb),
    .wbm_cti_i(cti_bus),   .wbm_bte_i(bte_bus),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o  (grant_o),   .timeout_o(timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Slave: acks one cycle after it sees stb; read data is the inverted address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ack <= 1'b0;
    else        s_ack <= slave_en && wbs_cyc_o && wbs_stb_o && !s_ack;
  end
  assign wbs_ack_i = s_ack | force_ack;
  assign wbs_dat_i = ~wbs_adr_o;
  assign wbs_err_i = 1'b0;
  assign wbs_rty_i = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expired(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired without the required event (t=%0t)", name, $time);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_term(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rst_n) return;
      if (wbm_ack_o[m] || wbm_err_o[m]) begin
        ok = 1'b1;
        return;
      end
    end
    expired($sformatf("term_wait_m%0d", m));
  endtask

  task automatic wait_grant(input logic [3:0] g);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant_o == g) return;
    end
    expired($sformatf("grant_wait_%b", g));
  endtask

  task automatic master_run(input int m, input logic [31:0] base, input int beats,
                            input logic we, input logic [31:0] wdata, input bit exp_err);
    exp_t e;
    bit   ok;
    m_cyc[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      m_adr[m] = base + 32'(4 * b);
      m_dat[m] = wdata + 32'(b);
      m_sel[m] = 4'hF;
      m_we[m]  = we;
      m_bte[m] = BTE_LINEAR;
      m_cti[m] = (beats == 1) ? CTI_CLASSIC : (b == beats - 1) ? CTI_END : CTI_INC_BURST;
      m_stb[m] = 1'b1;
      e.ack = exp_err ? 4'b0 : 4'(1 << m);
      e.err = exp_err ? 4'(1 << m) : 4'b0;
      e.adr = m_adr[m];
      e.dat = we ? m_dat[m] : ~m_adr[m];
      e.sel = 4'hF;
      e.we  = we;
      e.cti = m_cti[m];
      e.bte = BTE_LINEAR;
      exp_q[m].push_back(e);
      wait_term(m, ok);
      if (!ok) break;
      sync();
    end
    m_stb[m] = 1'b0;
    m_cyc[m] = 1'b0;
    m_cti[m] = CTI_CLASSIC;
  endtask

  // Monitor: grant handovers and master-side terminations.
  always @(negedge clk) begin
    if (grant_o !== prev_g) begin
      if (grant_o != 4'b0) begin
        check("gnt_gap", prev_g, 4'b0);
        if (gnt_q.size() == 0) check("gnt_unexpected", grant_o, 4'b0);
        else                   check("gnt_order", grant_o, gnt_q.pop_front());
      end
      prev_g <= grant_o;
    end
    if (rst_n && |(wbm_ack_o | wbm_err_o | wbm_rty_o)) begin
      int m;
      exp_t e;
      m = 0;
      for (int i = 3; i >= 0; i--) if (wbm_ack_o[i] | wbm_err_o[i] | wbm_rty_o[i]) m = i;
      if (wbm_ack_o[m]) ack_cnt[m] <= ack_cnt[m] + 1;
      if (exp_q[m].size() == 0) begin
        check("term_unexpected", {wbm_ack_o, wbm_err_o}, 8'b0);
      end else begin
        e = exp_q[m].pop_front();
        check("term", {wbm_ack_o, wbm_err_o, wbm_rty_o}, {e.ack, e.err, 4'b0});
        check("slv_adr", wbs_adr_o, e.adr);
        check("data", wbs_we_o ? wbs_dat_o : wbm_dat_o, e.dat);
        check("slv_ctl", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o}, {e.sel, e.we, e.cti, e.bte});
      end
    end
  end

  initial begin
    int base_cnt;
    int b1;
    bit hit;
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 4; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0; m_bte[i] = '0;
      ack_cnt[i] = 0;
    end
    prev_g = '0; slave_en = 1'b1; force_ack = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_bte_o, grant_o,
                      wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, '0);
    check("rst_adr", wbs_adr_o, 32'h0);
    check("rst_dat_sel", {wbs_dat_o, wbs_sel_o}, '0);
    check("rst_rd_pass", wbm_dat_o, 32'hFFFF_FFFF);
    repeat (3) sync();
    rst_n = 1'b1;
    sync();

    // Single master write with grant latency.
    gnt_q.push_back(4'b0100);
    fork
      master_run(2, 32'h100, 1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      begin
        @(negedge clk);
        check("lat_cycle_n", {grant_o, wbs_cyc_o}, {4'b0000, 1'b0});
        @(negedge clk);
        check("lat_cycle_n1", {grant_o, wbs_cyc_o, wbs_stb_o}, {4'b0100, 1'b1, 1'b1});
      end
    join
    repeat (3) sync();

    // Contention from reset: order 0,1,3.
    rst_n = 1'b0;
    repeat (2) sync();
    rst_n = 1'b1;
    sync();
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b1000);
    fork
      master_run(0, 32'h1000, 1, 1'b1, 32'h0000_00A0, 1'b0);
      master_run(1, 32'h1100, 1, 1'b1, 32'h0000_00B1, 1'b0);
      master_run(3, 32'h1300, 1, 1'b1, 32'h0000_00D3, 1'b0);
    join
    repeat (3) sync();

    // Burst hold: master 1 reads 8 beats while master 0 waits.
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b0001);
    b1 = ack_cnt[1];
    fork
      master_run(1, 32'h2000, 8, 1'b0, 32'h0, 1'b0);
      begin
        wait_grant(4'b0010);
        master_run(0, 32'h3000, 1, 1'b1, 32'h1234_5678, 1'b0);
      end
      begin
        wait_grant(4'b0001);
        check("burst_hold_beats", ack_cnt[1] - b1, 8);
      end
    join
    repeat (3) sync();

    // Watchdog fires on a dead slave; master 3 takes over afterwards.
    slave_en = 1'b0;
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b1000);
    fork
      master_run(1, 32'h400, 1, 1'b1, 32'hCAFE_0001, 1'b1);
      begin
        wait_grant(4'b0010);
        master_run(3, 32'h500, 1, 1'b1, 32'h0000_0033, 1'b0);
      end
      begin
        wait_grant(4'b0010);
        repeat (15) @(negedge clk);
        check("wd_not_early", {wbm_err_o, wbs_stb_o, timeout_o}, {4'b0000, 1'b1, 1'b0});
        @(negedge clk);
        check("wd_fire", {wbm_err_o, wbs_stb_o, timeout_o}, {4'b0010, 1'b0, 1'b0});
        slave_en = 1'b1;
        @(negedge clk);
        check("wd_pulse", {timeout_o, wbm_err_o}, {1'b1, 4'b0000});
        @(negedge clk);
        check("wd_pulse_end", timeout_o, 1'b0);
      end
    join
    repeat (3) sync();

    // Expiry race: ack arrives in the expiry cycle.
    slave_en = 1'b0;
    gnt_q.push_back(4'b0100);
    fork
      master_run(2, 32'h600, 1, 1'b1, 32'h0000_600D, 1'b0);
      begin
        wait_grant(4'b0100);
        repeat (16) @(posedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        check("race_stb_kept", {wbs_stb_o, wbm_err_o, wbm_ack_o}, {1'b1, 4'b0000, 4'b0100});
        sync();
        force_ack = 1'b0;
        @(negedge clk);
        check("race_no_timeout", timeout_o, 1'b0);
      end
    join
    slave_en = 1'b1;
    repeat (3) sync();

    // Reset during beat 3 of a burst, then priority restarts at master 0.
    gnt_q.push_back(4'b0100);
    base_cnt = ack_cnt[2];
    fork
      master_run(2, 32'h700, 8, 1'b0, 32'h0, 1'b0);
      begin
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
          @(posedge clk);
          if (ack_cnt[2] >= base_cnt + 2) hit = 1'b1;
        end
        if (!hit) expired("burst_beat2");
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ctl", {wbs_cyc_o, wbs_stb_o, wbs_cti_o, grant_o, wbm_ack_o, wbm_err_o,
                             wbm_rty_o, timeout_o}, '0);
        check("midrst_adr", wbs_adr_o, 32'h0);
      end
    join
    exp_q[2].delete();
    repeat (2) sync();
    rst_n = 1'b1;
    sync();
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b1000);
    fork
      master_run(0, 32'h800, 1, 1'b1, 32'h0000_0800, 1'b0);
      master_run(3, 32'h830, 1, 1'b1, 32'h0000_0830, 1'b0);
    join
    repeat (5) sync();

    for (int i = 0; i < 4; i++) check($sformatf("exp_left_m%0d", i), exp_q[i].size(), 0);
    check("gnt_left", gnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
